// File: rtl/network_mul_arbiter_if.sv
// Requester, response and multiplier signals of network_mul_arbiter.
// The slave modport is the arbiter side. The master modport is the requester/multiplier side.
interface network_mul_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [NREQ*W-1:0] resp_p;
  logic [W-1:0]      mul_din0;
  logic [W-1:0]      mul_din1;
  logic [W-1:0]      mul_dout;
  logic              idle;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, mul_dout,
    output req_ready, resp_valid, resp_p, mul_din0, mul_din1, idle
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready, mul_dout,
    input  req_ready, resp_valid, resp_p, mul_din0, mul_din1, idle
  );
endinterface

// File: rtl/network_mul_arbiter.sv
// Round-robin sharing of one combinational 16x16 multiplier among NREQ requesters.
// Granted operands are registered into the multiplier. The product is captured into a per-requester buffer.
module network_mul_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  network_mul_arbiter_if.slave bus
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic              s1_valid;
  logic [IDW-1:0]    s1_id;
  logic [IDW-1:0]    rr_ptr;
  logic [W-1:0]      din0_q;
  logic [W-1:0]      din1_q;
  logic [NREQ-1:0]   resp_valid_q;
  logic [NREQ*W-1:0] resp_p_q;

  logic [NREQ-1:0]   eligible;
  logic              grant_any;
  logic [IDW-1:0]    grant_id;
  int unsigned       idx;
  logic [W-1:0]      grant_a;
  logic [W-1:0]      grant_b;

  // A requester with a product in flight or waiting in its buffer is not eligible.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      eligible[i] = bus.req_valid[i] && !resp_valid_q[i] &&
                    !(s1_valid && (s1_id == IDW'(i)));
    end
  end

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    grant_a = bus.req_a[32'(grant_id)*W +: W];
    grant_b = bus.req_b[32'(grant_id)*W +: W];
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant_any && !ap_rst) begin
      bus.req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid     <= 1'b0;
      s1_id        <= '0;
      rr_ptr       <= IDW'(NREQ - 1);
      din0_q       <= '0;
      din1_q       <= '0;
      resp_valid_q <= '0;
      resp_p_q     <= '0;
    end else begin
      s1_valid <= grant_any;
      if (grant_any) begin
        s1_id  <= grant_id;
        rr_ptr <= grant_id;
        din0_q <= grant_a;
        din1_q <= grant_b;
      end
      // Capture and drain never meet on one buffer, so the priority order here does not matter.
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (s1_valid && (s1_id == IDW'(i))) begin
          resp_valid_q[i]      <= 1'b1;
          resp_p_q[i*W +: W]   <= bus.mul_dout;
        end else if (resp_valid_q[i] && bus.resp_ready[i]) begin
          resp_valid_q[i]      <= 1'b0;
        end
      end
    end
  end

  assign bus.mul_din0   = din0_q;
  assign bus.mul_din1   = din1_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_p     = resp_p_q;
  assign bus.idle       = !s1_valid && !(|resp_valid_q);
endmodule

// File: tb/tb_network_mul_arbiter.sv
// Self-checking bench for network_mul_arbiter: directed scenarios plus random stress.
// A behavioural model checks the outputs on every cycle.
module tb_network_mul_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  network_mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();
  network_mul_arbiter #(.NREQ(NREQ), .W(W)) dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [15:0] mulw(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[15:0];
  endfunction

  // Stand-in for the external combinational multiplier.
  always_comb bus.mul_dout = mulw(bus.mul_din0, bus.mul_din1);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: one multiply in flight, the last grant, and per-requester buffers with expected products.
  bit             m_s1 = 0;
  int             m_s1id = 0;
  logic [15:0]    m_s1a = '0, m_s1b = '0;
  int             m_ptr = NREQ - 1;
  bit             m_buf [NREQ];
  logic [15:0]    m_val [NREQ];

  always @(negedge ap_clk) begin
    logic [NREQ-1:0] exp_ready, exp_rv;
    int g;
    if (ap_rst) begin
      check("ready_in_reset", bus.req_ready, '0);
      m_s1 = 0; m_ptr = NREQ - 1; m_s1a = '0; m_s1b = '0;
      for (int i = 0; i < NREQ; i++) m_buf[i] = 0;
    end else begin
      exp_ready = '0; exp_rv = '0; g = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (g < 0 && bus.req_valid[j] && !m_buf[j] && !(m_s1 && m_s1id == j)) g = j;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      for (int i = 0; i < NREQ; i++) exp_rv[i] = m_buf[i];
      check("req_ready", bus.req_ready, exp_ready);
      check("resp_valid", bus.resp_valid, exp_rv);
      check("idle", bus.idle, !m_s1 && exp_rv == '0);
      check("mul_din0", bus.mul_din0, m_s1a);
      check("mul_din1", bus.mul_din1, m_s1b);
      for (int i = 0; i < NREQ; i++)
        if (m_buf[i]) check("resp_p", bus.resp_p[i*W +: W], m_val[i]);
      for (int i = 0; i < NREQ; i++)
        if (m_buf[i] && bus.resp_ready[i]) m_buf[i] = 0;
      if (m_s1) begin m_buf[m_s1id] = 1; m_val[m_s1id] = mulw(m_s1a, m_s1b); end
      m_s1 = (g >= 0);
      if (g >= 0) begin
        m_s1id = g; m_ptr = g;
        m_s1a = bus.req_a[g*W +: W];
        m_s1b = bus.req_b[g*W +: W];
      end
    end
  end

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    bus.req_valid = '0;
    next_cycle();
    next_cycle();
    ap_rst = 1'b0;
  endtask

  task automatic offer_wait(input int i, input logic [15:0] a, input logic [15:0] b, output logic [15:0] p);
    bit got;
    bus.req_valid[i] = 1'b1;
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      #1;
      got = bus.req_ready[i];
      next_cycle();
    end
    bus.req_valid[i] = 1'b0;
    if (!got) check("accept_timeout", 0, 1);
    got = 0;
    p = 'x;
    for (int t = 0; t < 20 && !got; t++) begin
      #1;
      if (bus.resp_valid[i]) begin got = 1; p = bus.resp_p[i*W +: W]; end
      next_cycle();
    end
    if (!got) check("resp_timeout", 0, 1);
  endtask

  initial begin
    logic [15:0] p;
    logic [NREQ-1:0] acc;
    int glog [16];
    int nlog, s0, s2;
    bit seen1, got;

    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.resp_ready = '0;
    next_cycle();
    do_reset();
    #1;
    check("rst_idle", bus.idle, 1);
    check("rst_resp_valid", bus.resp_valid, '0);
    check("rst_resp_p", bus.resp_p, '0);
    check("rst_din0", bus.mul_din0, '0);

    // Single operation with cycle-exact latency.
    bus.resp_ready = '1;
    bus.req_valid[0] = 1'b1; bus.req_a[15:0] = 16'd300; bus.req_b[15:0] = 16'd300;
    #1 check("single_ready_c0", bus.req_ready, 4'b0001);
    next_cycle(); bus.req_valid[0] = 1'b0;
    #1 check("single_busy_c1", bus.idle, 0);
    next_cycle();
    #1 check("single_rv_c2", bus.resp_valid, 4'b0001);
    check("single_p_c2", bus.resp_p[15:0], 16'h5F90);
    next_cycle();
    #1 check("single_idle_c3", bus.idle, 1);

    offer_wait(0, 16'hFFFD, 16'd7, p);    check("mul_neg3x7", p, 16'hFFEB);
    offer_wait(0, 16'h8000, 16'hFFFF, p); check("mul_min_x_neg1", p, 16'h8000);
    offer_wait(0, 16'h7FFF, 16'h7FFF, p); check("mul_max_sq", p, 16'h0001);
    offer_wait(0, 16'h0000, 16'hFFFF, p); check("mul_zero", p, 16'h0000);
    offer_wait(3, 16'd300, 16'd300, p);   check("mul_req3", p, 16'h5F90);

    // Fairness: four continuous requesters.
    do_reset();
    bus.resp_ready = '1;
    for (int i = 0; i < NREQ; i++) begin bus.req_a[i*W +: W] = rand_op(); bus.req_b[i*W +: W] = rand_op(); end
    bus.req_valid = '1;
    nlog = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      acc = bus.req_ready;
      for (int i = 0; i < NREQ; i++) if (acc[i] && nlog < 16) begin glog[nlog] = i; nlog++; end
      next_cycle();
      for (int i = 0; i < NREQ; i++)
        if (acc[i]) begin bus.req_a[i*W +: W] = rand_op(); bus.req_b[i*W +: W] = rand_op(); end
    end
    check("fair_grants_per_cycle", nlog, 12);
    for (int k = 0; k < nlog; k++) check("fair_order", glog[k], k % 4);
    bus.req_valid = '0;
    next_cycle(); next_cycle(); next_cycle();

    // Backpressure: requester 1 holds its product while 0 and 2 keep running.
    do_reset();
    bus.resp_ready = 4'b1101;
    bus.req_valid = 4'b0111;
    seen1 = 0; s0 = 0; s2 = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (seen1 && bus.resp_valid[1]) check("bp_req1_blocked", bus.req_ready[1], 0);
      if (bus.req_ready[1]) seen1 = 1;
      if (bus.req_ready[0]) s0++;
      if (bus.req_ready[2]) s2++;
      next_cycle();
    end
    check("bp_rv1_held", bus.resp_valid[1], 1);
    check("bp_req0_served", s0 >= 3, 1);
    check("bp_req2_served", s2 >= 3, 1);
    bus.resp_ready[1] = 1'b1;
    #1 check("bp_release_same_cycle", bus.req_ready[1], 0);
    next_cycle();
    got = 0;
    for (int t = 0; t < 8 && !got; t++) begin
      #1;
      got = bus.req_ready[1];
      next_cycle();
    end
    check("bp_req1_regranted", got, 1);
    bus.req_valid = '0;
    next_cycle(); next_cycle(); next_cycle();

    // Reset while a product for requester 2 is in flight.
    do_reset();
    bus.resp_ready = '1;
    bus.req_valid = 4'b0100;
    #1 check("mf_grant2", bus.req_ready, 4'b0100);
    next_cycle();
    bus.req_valid = '0;
    ap_rst = 1'b1;
    next_cycle(); next_cycle();
    ap_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("mf_no_resp", bus.resp_valid, '0);
      check("mf_idle", bus.idle, 1);
      next_cycle();
    end
    bus.req_valid = 4'b0101;
    #1 check("mf_req0_first", bus.req_ready, 4'b0001);
    next_cycle();
    bus.req_valid = '0;
    next_cycle(); next_cycle(); next_cycle();

    // Random stress with protocol-respecting requesters.
    acc = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || acc[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 3) != 0);
          bus.req_a[i*W +: W] = rand_op();
          bus.req_b[i*W +: W] = rand_op();
        end
        bus.resp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      ap_rst = ($urandom_range(0, 499) == 0);
      #3;
      acc = bus.req_valid & bus.req_ready;
      next_cycle();
    end
    ap_rst = 1'b0;
    bus.req_valid = '0;
    bus.resp_ready = '1;
    repeat (4) next_cycle();
    #1 check("end_idle", bus.idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
